// File: rtl/matrix_digit_scanner.sv
// ============================================================================
// Module   : matrix_digit_scanner
// Brief    : Time-multiplexed driver for NUM_DIGITS side-by-side 5x7 dot-matrix
//            digits. The display only changes at frame boundaries.
//            Optional macro BLANK_LEADING_ZERO_EN blanks leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_digit_scanner #(
    parameter int NUM_DIGITS = 2,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    output logic [6:0]                row_n,
    output logic [5*NUM_DIGITS-1:0]   cols,
    output logic                      frame_done
);

    localparam int             PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]     ROW_LAST   = 3'd6;
    localparam logic [3:0]     BLANK      = 4'hF;

    // Glyph rows are packed row 6 first so row r sits at bits [5r+4:5r].
    function automatic logic [4:0] font_row(input logic [3:0] d, input logic [2:0] r);
        logic [34:0] g;
        case (d)
            4'd0:    g = {5'h0E, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h0E};
            4'd1:    g = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0C, 5'h04};
            4'd2:    g = {5'h1F, 5'h08, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
            4'd3:    g = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h02, 5'h1F};
            4'd4:    g = {5'h02, 5'h02, 5'h1F, 5'h12, 5'h0A, 5'h06, 5'h02};
            4'd5:    g = {5'h0E, 5'h11, 5'h01, 5'h01, 5'h1E, 5'h10, 5'h1F};
            4'd6:    g = {5'h0E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h08, 5'h06};
            4'd7:    g = {5'h08, 5'h08, 5'h08, 5'h04, 5'h02, 5'h01, 5'h1F};
            4'd8:    g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            4'd9:    g = {5'h0C, 5'h02, 5'h01, 5'h0F, 5'h11, 5'h11, 5'h0E};
            default: g = '0;
        endcase
        font_row = (r <= ROW_LAST) ? g[5*int'(r) +: 5] : 5'd0;
    endfunction

    logic [PW-1:0]             presc_q, presc_d;
    logic [2:0]                row_q, row_d;
    logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0]   active_q, active_d;
    logic [6:0]                row_n_q, row_n_d;
    logic [5*NUM_DIGITS-1:0]   cols_q, cols_d;
    logic                      frame_done_q, frame_done_d;

    logic                      w_row_tick;
    logic                      w_frame;
    logic [4*NUM_DIGITS-1:0]   w_copy_src;
    logic [4*NUM_DIGITS-1:0]   w_copy;
    logic [5*NUM_DIGITS-1:0]   w_glyph_row;

    assign w_row_tick = enable && (presc_q == PRESC_LAST);
    assign w_frame    = w_row_tick && (row_q == ROW_LAST);
    // A load landing on the boundary is forwarded straight into the active copy.
    assign w_copy_src = load ? digits : pending_q;

`ifdef BLANK_LEADING_ZERO_EN
    always_comb begin
        logic still_lead;
        still_lead = 1'b1;
        w_copy     = w_copy_src;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (still_lead && (w_copy_src[4*k +: 4] == 4'd0)) begin
                w_copy[4*k +: 4] = BLANK;
            end else begin
                still_lead = 1'b0;
            end
        end
    end
`else
    assign w_copy = w_copy_src;
`endif

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_cols
            assign w_glyph_row[5*k +: 5] = font_row(active_q[4*k +: 4], row_q);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            row_q        <= '0;
            pending_q    <= {NUM_DIGITS{BLANK}};
            active_q     <= {NUM_DIGITS{BLANK}};
            row_n_q      <= 7'h7F;
            cols_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            row_q        <= row_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            row_n_q      <= row_n_d;
            cols_q       <= cols_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        presc_d      = presc_q;
        row_d        = row_q;
        pending_d    = load ? digits : pending_q;
        active_d     = w_frame ? w_copy : active_q;
        frame_done_d = w_frame;
        if (enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                row_d   = (row_q == ROW_LAST) ? 3'd0 : row_q + 3'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_comb begin
        row_n_d = 7'h7F;
        cols_d  = '0;
        if (enable) begin
            row_n_d = ~(7'd1 << row_q);
            cols_d  = w_glyph_row;
        end
    end

    assign row_n      = row_n_q;
    assign cols       = cols_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire
